sonar_sweep_uc: RTL and testbench
=================================

Name: sonar_sweep_uc

Overview:
Control unit for the sonar that sweeps the servo across N_POS angular positions.
- At each position it rotates, then takes MEAS_PER_POS measurements, and transmits each one.
- Supports single-sweep and continuous ping-pong sweep modes, with a handshake timeout.
- Sits between the top-level sonar controller and the servo, ultrasonic-interface and serial-transmit datapaths, which it drives with one-cycle start pulses.

Parameters:
N_POS, 8, number of sweep positions (must be >= 2); posicao width PW = $clog2(N_POS)
MEAS_PER_POS, 1, measurements per position (must be >= 1)
TIMEOUT_CYCLES, 1000000, max cycles in any wait state before error (must be >= 2)

Ports:
clock  in  1  system clock
reset  in  1  reset
ligar  in  1  enable; level-sensitive, sampled synchronously
continuo  in  1  1 = continuous ping-pong sweep, 0 = single sweep; sampled in PROXIMA
giro_pronto  in  1  servo reached commanded position
medida_pronto  in  1  distance measurement complete
envio_pronto  in  1  transmission complete
girar  out  1  one-cycle pulse: move servo to posicao
medir  out  1  one-cycle pulse: start measurement
transmitir  out  1  one-cycle pulse: start transmission
pronto  out  1  one-cycle pulse: single sweep finished
posicao  out  PW  current sweep position index
direcao  out  1  0 = ascending, 1 = descending
erro_timeout  out  1  high while in ERRO
db_estado  out  4  state code, debug

Behaviour:
- Reset is asynchronous, active-high; clock is clock. Reset forces INICIAL; posicao=0, direcao=0, all counters=0.
- All outputs are registered-state decoded (Moore). Every pulse and flag output is 0 at reset.
- States and db_estado codes: INICIAL 0, PREPARA 1, FAZ_ROTACAO 2, AGUARDA_ROTACAO 3, FAZ_MEDIDA 4, AGUARDA_MEDIDA 5, FAZ_TRANSMISSAO 6, AGUARDA_TRANSMISSAO 7, PROXIMA 8, ERRO E, FIM F. Unused codes -> INICIAL.
- INICIAL: ligar=1 -> PREPARA.
- PREPARA: posicao=0, direcao=0, cnt_med=0 -> FAZ_ROTACAO.
- FAZ_ROTACAO (girar=1) -> AGUARDA_ROTACAO; leaves on giro_pronto -> FAZ_MEDIDA.
- FAZ_MEDIDA (medir=1) -> AGUARDA_MEDIDA; leaves on medida_pronto -> FAZ_TRANSMISSAO.
- FAZ_TRANSMISSAO (transmitir=1) -> AGUARDA_TRANSMISSAO; leaves on envio_pronto -> PROXIMA.
- PROXIMA, in priority order:
  - cnt_med < MEAS_PER_POS-1: cnt_med++, go to FAZ_MEDIDA (no rotation).
  - Otherwise cnt_med=0 and the end-of-sweep test applies. End of sweep is (direcao=0 and posicao=N_POS-1) or (direcao=1 and posicao=0).
  - Not end of sweep: posicao steps +1 or -1 per direcao, go to FAZ_ROTACAO.
  - End of sweep and continuo=1: toggle direcao, step posicao one in the new direction (N_POS-1 -> N_POS-2; 0 -> 1), go to FAZ_ROTACAO.
  - End of sweep and continuo=0: go to FIM.
- FIM: pronto=1 for one cycle -> INICIAL.
- Abort: ligar=0 in any state except ERRO -> INICIAL on the next edge. Counters are cleared; posicao/direcao hold their values until the next PREPARA.
- Timeout counter:
  - Cleared on entry to each AGUARDA_* state and increments each cycle spent there.
  - Reaching TIMEOUT_CYCLES-1 without the matching done signal -> ERRO.
  - Done and timeout in the same cycle: done wins.
- ERRO: erro_timeout=1; held until ligar=0, then INICIAL. ligar high keeps ERRO; reset also exits.
- Done inputs outside their AGUARDA state are ignored. Stale done pulses are not latched.
- posicao never exceeds N_POS-1 and never wraps.

Optional Feature:
SONAR_UC_TIMEOUT_EN
- Defined: timeout counter and ERRO state are present, as described above.
- Undefined: no counter is instantiated; AGUARDA_* states wait indefinitely; erro_timeout is tied 0; ERRO is unreachable (its code falls to default).

Decomposition:
- Package sonar_pkg: the 4-bit state encodings as localparams and the db_estado codes, shared with sonar top-level debug displays.
- Sub-module sonar_timeout_timer (parameter TIMEOUT_CYCLES; ports clock, reset, clear, enable, estouro). Instantiated only under SONAR_UC_TIMEOUT_EN.
- Position/measurement counters stay inline.

Test Plan:
- N_POS=4, MEAS_PER_POS=2, continuo=0, ligar=1, dones returned after 3 cycles -> girar×4 at posicao 0,1,2,3; medir×8; transmitir×8; one pronto; returns to db_estado=0.
- N_POS=4, MEAS_PER_POS=1, continuo=1 -> girar sequence at posicao 0,1,2,3,2,1,0,1; direcao flips at 3 and at 0; pronto never asserted.
- TIMEOUT_CYCLES=16, medida_pronto withheld -> ERRO entered 16 cycles after AGUARDA_MEDIDA entry; erro_timeout=1, db_estado=E. ligar=0 -> INICIAL next cycle.
- medida_pronto asserted exactly on the timeout cycle -> FAZ_TRANSMISSAO, no error.
- ligar dropped in AGUARDA_TRANSMISSAO -> db_estado=0 next cycle. Re-raising ligar -> PREPARA with posicao reset to 0.
- reset pulsed asynchronously mid AGUARDA_ROTACAO (between edges) -> outputs 0, db_estado=0 immediately. giro_pronto arriving afterwards is ignored.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared state encodings for the sonar sweep control unit.
// The numeric codes are also the db_estado values shown on the sonar
// top-level debug displays, so they must stay stable.
package sonar_pkg;

   localparam int unsigned STATE_W = 4;

   localparam logic [STATE_W-1:0] ST_INICIAL             = 4'h0;
   localparam logic [STATE_W-1:0] ST_PREPARA             = 4'h1;
   localparam logic [STATE_W-1:0] ST_FAZ_ROTACAO         = 4'h2;
   localparam logic [STATE_W-1:0] ST_AGUARDA_ROTACAO     = 4'h3;
   localparam logic [STATE_W-1:0] ST_FAZ_MEDIDA          = 4'h4;
   localparam logic [STATE_W-1:0] ST_AGUARDA_MEDIDA      = 4'h5;
   localparam logic [STATE_W-1:0] ST_FAZ_TRANSMISSAO     = 4'h6;
   localparam logic [STATE_W-1:0] ST_AGUARDA_TRANSMISSAO = 4'h7;
   localparam logic [STATE_W-1:0] ST_PROXIMA             = 4'h8;
   localparam logic [STATE_W-1:0] ST_ERRO                = 4'hE;
   localparam logic [STATE_W-1:0] ST_FIM                 = 4'hF;

   typedef enum logic [STATE_W-1:0] {
      INICIAL             = ST_INICIAL,
      PREPARA             = ST_PREPARA,
      FAZ_ROTACAO         = ST_FAZ_ROTACAO,
      AGUARDA_ROTACAO     = ST_AGUARDA_ROTACAO,
      FAZ_MEDIDA          = ST_FAZ_MEDIDA,
      AGUARDA_MEDIDA      = ST_AGUARDA_MEDIDA,
      FAZ_TRANSMISSAO     = ST_FAZ_TRANSMISSAO,
      AGUARDA_TRANSMISSAO = ST_AGUARDA_TRANSMISSAO,
      PROXIMA             = ST_PROXIMA,
      ERRO                = ST_ERRO,
      FIM                 = ST_FIM
   } estado_t;

endpackage

// File: rtl/sonar_sweep_uc_if.sv
// Start/done handshakes between the sweep control unit and the servo,
// ultrasonic and serial-transmit datapaths.
//   girar/giro_pronto        : servo move request / servo reached position
//   medir/medida_pronto      : measurement request / measurement complete
//   transmitir/envio_pronto  : transmission request / transmission complete
// master = control unit side, slave = datapath side.
interface sonar_sweep_uc_if;

   logic girar;
   logic giro_pronto;
   logic medir;
   logic medida_pronto;
   logic transmitir;
   logic envio_pronto;

   modport master (
      output girar, medir, transmitir,
      input  giro_pronto, medida_pronto, envio_pronto
   );

   modport slave (
      input  girar, medir, transmitir,
      output giro_pronto, medida_pronto, envio_pronto
   );

endinterface

// File: rtl/sonar_timeout_timer.sv
// Wait-state watchdog for the sweep control unit.
//   clock, reset : clock, async active-high reset
//   clear        : return count to zero (held while not waiting)
//   enable       : count one per cycle while waiting
//   estouro      : count has reached TIMEOUT_CYCLES-1 while enabled
module sonar_timeout_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic estouro
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // Saturates at LAST so a long wait can never wrap back to zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LAST)) begin
         count <= count + CW'(1);
      end
   end

   assign estouro = enable && (count == LAST);

endmodule

// File: rtl/sonar_sweep_uc.sv
// Sonar sweep control unit: steps the servo over N_POS positions, takes
// MEAS_PER_POS measurements per position and transmits each one.
// Single sweep (continuo=0) or continuous ping-pong sweep (continuo=1).
//   clock, reset  : clock, async active-high reset
//   ligar         : enable; dropping it aborts back to INICIAL
//   continuo      : sweep mode, sampled in PROXIMA
//   dp            : start pulses / done inputs to the datapaths
//   pronto        : one-cycle pulse when a single sweep finishes
//   posicao       : current position index
//   direcao       : 0 ascending, 1 descending
//   erro_timeout  : high while in ERRO
//   db_estado     : state code for debug displays
// Build option SONAR_UC_TIMEOUT_EN adds the wait-state watchdog and ERRO.
module sonar_sweep_uc
   import sonar_pkg::*;
#(
   parameter int unsigned N_POS          = 8,
   parameter int unsigned MEAS_PER_POS   = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     ligar,
   input  logic                     continuo,
   sonar_sweep_uc_if.master         dp,
   output logic                     pronto,
   output logic [$clog2(N_POS)-1:0] posicao,
   output logic                     direcao,
   output logic                     erro_timeout,
   output logic [3:0]               db_estado
);

   localparam int unsigned PW = $clog2(N_POS);
   localparam int unsigned MW = (MEAS_PER_POS > 1) ? $clog2(MEAS_PER_POS) : 1;
   localparam logic [PW-1:0] POS_LAST  = PW'(N_POS - 1);
   localparam logic [MW-1:0] MEAS_LAST = MW'(MEAS_PER_POS - 1);

   if (N_POS < 2 || MEAS_PER_POS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("sonar_sweep_uc: N_POS>=2, MEAS_PER_POS>=1, TIMEOUT_CYCLES>=2");
   end

   estado_t       state, state_n;
   logic [PW-1:0] posicao_n;
   logic          direcao_n;
   logic [MW-1:0] cnt_med, cnt_med_n;
   logic          fim_varredura;

`ifdef SONAR_UC_TIMEOUT_EN
   logic aguarda;
   logic estouro;

   assign aguarda = (state == AGUARDA_ROTACAO) || (state == AGUARDA_MEDIDA) ||
                    (state == AGUARDA_TRANSMISSAO);

   // Held clear outside the wait states, so each wait starts from zero.
   sonar_timeout_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (!aguarda),
      .enable  (aguarda),
      .estouro (estouro)
   );
`endif

   assign fim_varredura = direcao ? (posicao == '0) : (posicao == POS_LAST);

   // Next state and next counter values; done inputs beat the watchdog.
   always_comb begin
      state_n   = state;
      posicao_n = posicao;
      direcao_n = direcao;
      cnt_med_n = cnt_med;
      if (!ligar) begin
         state_n   = INICIAL;
         cnt_med_n = '0;
      end else begin
         unique case (state)
            INICIAL: state_n = PREPARA;
            PREPARA: begin
               posicao_n = '0;
               direcao_n = 1'b0;
               cnt_med_n = '0;
               state_n   = FAZ_ROTACAO;
            end
            FAZ_ROTACAO: state_n = AGUARDA_ROTACAO;
            AGUARDA_ROTACAO: begin
               if (dp.giro_pronto) state_n = FAZ_MEDIDA;
`ifdef SONAR_UC_TIMEOUT_EN
               else if (estouro) state_n = ERRO;
`endif
            end
            FAZ_MEDIDA: state_n = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA: begin
               if (dp.medida_pronto) state_n = FAZ_TRANSMISSAO;
`ifdef SONAR_UC_TIMEOUT_EN
               else if (estouro) state_n = ERRO;
`endif
            end
            FAZ_TRANSMISSAO: state_n = AGUARDA_TRANSMISSAO;
            AGUARDA_TRANSMISSAO: begin
               if (dp.envio_pronto) state_n = PROXIMA;
`ifdef SONAR_UC_TIMEOUT_EN
               else if (estouro) state_n = ERRO;
`endif
            end
            PROXIMA: begin
               if (cnt_med != MEAS_LAST) begin
                  cnt_med_n = cnt_med + MW'(1);
                  state_n   = FAZ_MEDIDA;
               end else begin
                  cnt_med_n = '0;
                  if (!fim_varredura) begin
                     posicao_n = direcao ? (posicao - PW'(1)) : (posicao + PW'(1));
                     state_n   = FAZ_ROTACAO;
                  end else if (continuo) begin
                     // Turn around and step one position in the new direction.
                     direcao_n = !direcao;
                     posicao_n = direcao ? (posicao + PW'(1)) : (posicao - PW'(1));
                     state_n   = FAZ_ROTACAO;
                  end else begin
                     state_n = FIM;
                  end
               end
            end
`ifdef SONAR_UC_TIMEOUT_EN
            ERRO: state_n = ERRO;
`endif
            FIM:     state_n = INICIAL;
            default: state_n = INICIAL;
         endcase
      end
   end

   // State, counters and registered Moore outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= INICIAL;
         posicao       <= '0;
         direcao       <= 1'b0;
         cnt_med       <= '0;
         dp.girar      <= 1'b0;
         dp.medir      <= 1'b0;
         dp.transmitir <= 1'b0;
         pronto        <= 1'b0;
      end else begin
         state         <= state_n;
         posicao       <= posicao_n;
         direcao       <= direcao_n;
         cnt_med       <= cnt_med_n;
         dp.girar      <= (state_n == FAZ_ROTACAO);
         dp.medir      <= (state_n == FAZ_MEDIDA);
         dp.transmitir <= (state_n == FAZ_TRANSMISSAO);
         pronto        <= (state_n == FIM);
      end
   end

`ifdef SONAR_UC_TIMEOUT_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         erro_timeout <= 1'b0;
      end else begin
         erro_timeout <= (state_n == ERRO);
      end
   end
`else
   assign erro_timeout = 1'b0;
`endif

   assign db_estado = state;

endmodule

// File: tb/tb_sonar_sweep_uc.sv
module tb_sonar_sweep_uc;

   localparam int EV_GIRAR  = 1;
   localparam int EV_MEDIR  = 2;
   localparam int EV_TRANS  = 3;
   localparam int EV_PRONTO = 4;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset;
   logic       ligar_a, continuo_a, ligar_b, continuo_b;
   logic       pronto_a, pronto_b, dir_a, dir_b, erro_a, erro_b;
   logic [1:0] pos_a, pos_b;
   logic [3:0] db_a, db_b;
   logic       giro_auto_a, giro_man_a, med_auto_a, med_man_a, env_auto_a;
   logic       auto_g_a, auto_m_a, auto_e_a;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   sonar_sweep_uc_if if_a ();
   sonar_sweep_uc_if if_b ();

   assign if_a.giro_pronto   = giro_auto_a | giro_man_a;
   assign if_a.medida_pronto = med_auto_a | med_man_a;
   assign if_a.envio_pronto  = env_auto_a;

   sonar_sweep_uc #(.N_POS(4), .MEAS_PER_POS(2), .TIMEOUT_CYCLES(16)) u_dut_a (
      .clock (clock), .reset (reset), .ligar (ligar_a), .continuo (continuo_a),
      .dp (if_a), .pronto (pronto_a), .posicao (pos_a), .direcao (dir_a),
      .erro_timeout (erro_a), .db_estado (db_a)
   );

   sonar_sweep_uc #(.N_POS(4), .MEAS_PER_POS(1), .TIMEOUT_CYCLES(16)) u_dut_b (
      .clock (clock), .reset (reset), .ligar (ligar_b), .continuo (continuo_b),
      .dp (if_b), .pronto (pronto_b), .posicao (pos_b), .direcao (dir_b),
      .erro_timeout (erro_b), .db_estado (db_b)
   );

   // Datapath model for A: each request answered with a done pulse 3 cycles later.
   initial begin : resp_a
      int dg, dm, de;
      dg = 0; dm = 0; de = 0;
      giro_auto_a = 1'b0; med_auto_a = 1'b0; env_auto_a = 1'b0;
      forever begin
         @(negedge clock);
         giro_auto_a = auto_g_a && (dg == 1);
         med_auto_a  = auto_m_a && (dm == 1);
         env_auto_a  = auto_e_a && (de == 1);
         if (dg > 0) dg--;
         if (dm > 0) dm--;
         if (de > 0) de--;
         if (!auto_g_a) dg = 0; else if (if_a.girar) dg = 3;
         if (!auto_m_a) dm = 0; else if (if_a.medir) dm = 3;
         if (!auto_e_a) de = 0; else if (if_a.transmitir) de = 3;
      end
   end

   // Datapath model for B, always answering.
   initial begin : resp_b
      int dg, dm, de;
      dg = 0; dm = 0; de = 0;
      if_b.giro_pronto = 1'b0; if_b.medida_pronto = 1'b0; if_b.envio_pronto = 1'b0;
      forever begin
         @(negedge clock);
         if_b.giro_pronto   = (dg == 1);
         if_b.medida_pronto = (dm == 1);
         if_b.envio_pronto  = (de == 1);
         if (dg > 0) dg--;
         if (dm > 0) dm--;
         if (de > 0) de--;
         if (if_b.girar) dg = 3;
         if (if_b.medir) dm = 3;
         if (if_b.transmitir) de = 3;
      end
   end

   task automatic wait_a(input logic [3:0] st, input int p, output bit ok);
      int b;
      b = 0;
      while (!((db_a == st) && (p < 0 || int'(pos_a) == p)) && b < 2000) begin
         @(negedge clock);
         b++;
      end
      ok = (db_a == st) && (p < 0 || int'(pos_a) == p);
   endtask

   task automatic idle_a();
      ligar_a = 1'b0;
      repeat (5) @(negedge clock);
   endtask

   task automatic test_reset();
      logic [6:0] flags;
      #12;
      flags = {if_a.girar, if_a.medir, if_a.transmitir, pronto_a, erro_a, dir_a, pronto_b};
      n_checks++;
      if (flags !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 0000000", flags);
      end
      n_checks++;
      if (db_a !== 4'h0 || db_b !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_state: got %h/%h expected 0/0", db_a, db_b);
      end
      n_checks++;
      if (pos_a !== 2'd0 || erro_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pos: got pos %0d erro_b %b expected 0/0", pos_a, erro_b);
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      n_checks++;
      if (db_a !== 4'h0) begin
         n_fail++;
         $display("FAIL idle_off: got %h expected 0", db_a);
      end
   endtask

   task automatic test_single_sweep();
      int got, e, b;
      exp_q.delete();
      for (int p = 0; p < 4; p++) begin
         exp_q.push_back(EV_GIRAR * 16 + p);
         for (int m = 0; m < 2; m++) begin
            exp_q.push_back(EV_MEDIR * 16 + p);
            exp_q.push_back(EV_TRANS * 16 + p);
         end
      end
      exp_q.push_back(EV_PRONTO * 16 + 3);
      continuo_a = 1'b0;
      ligar_a = 1'b1;
      b = 0;
      while (exp_q.size() > 0 && b < 3000) begin
         @(negedge clock);
         b++;
         got = -1;
         if (if_a.girar)           got = EV_GIRAR * 16 + int'(pos_a);
         else if (if_a.medir)      got = EV_MEDIR * 16 + int'(pos_a);
         else if (if_a.transmitir) got = EV_TRANS * 16 + int'(pos_a);
         else if (pronto_a)        got = EV_PRONTO * 16 + int'(pos_a);
         if (got >= 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL single_event: got code %0d expected %0d", got, e);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL single_timeout: got %0d events left expected 0", exp_q.size());
      end
      ligar_a = 1'b0;
      @(negedge clock);
      n_checks++;
      if (db_a !== 4'h0 || pronto_a !== 1'b0) begin
         n_fail++;
         $display("FAIL single_return: got state %h pronto %b expected 0/0", db_a, pronto_a);
      end
      idle_a();
   endtask

   task automatic test_continuous();
      int seq_p[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
      int seq_d[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
      int got, e, b;
      bit saw_pronto;
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(EV_GIRAR * 16 + seq_d[i] * 8 + seq_p[i]);
      saw_pronto = 1'b0;
      continuo_b = 1'b1;
      ligar_b = 1'b1;
      b = 0;
      while (exp_q.size() > 0 && b < 3000) begin
         @(negedge clock);
         b++;
         if (pronto_b) saw_pronto = 1'b1;
         if (if_b.girar) begin
            got = EV_GIRAR * 16 + int'(dir_b) * 8 + int'(pos_b);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) begin
               n_fail++;
               $display("FAIL cont_girar: got code %0d expected %0d", got, e);
            end
         end
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL cont_timeout: got %0d events left expected 0", exp_q.size());
      end
      n_checks++;
      if (saw_pronto !== 1'b0) begin
         n_fail++;
         $display("FAIL cont_pronto: got %b expected 0", saw_pronto);
      end
      ligar_b = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   task automatic test_abort();
      bit ok;
      ligar_a = 1'b1;
      wait_a(4'h7, 2, ok);
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_reach: got state %h pos %0d expected 7/2", db_a, pos_a);
      end
      ligar_a = 1'b0;
      @(negedge clock);
      n_checks++;
      if (db_a !== 4'h0 || pos_a !== 2'd2) begin
         n_fail++;
         $display("FAIL abort_state: got %h pos %0d expected 0 pos 2", db_a, pos_a);
      end
      ligar_a = 1'b1;
      @(negedge clock);
      n_checks++;
      if (db_a !== 4'h1) begin
         n_fail++;
         $display("FAIL abort_prepara: got %h expected 1", db_a);
      end
      @(negedge clock);
      n_checks++;
      if (db_a !== 4'h2 || pos_a !== 2'd0 || if_a.girar !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_restart: got %h pos %0d girar %b expected 2 pos 0 girar 1",
                  db_a, pos_a, if_a.girar);
      end
      idle_a();
   endtask

`ifdef SONAR_UC_TIMEOUT_EN
   task automatic test_timeout();
      bit ok;
      int cyc;
      auto_m_a = 1'b0;
      ligar_a = 1'b1;
      wait_a(4'h5, -1, ok);
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_reach: got %h expected 5", db_a);
      end
      cyc = 0;
      while (db_a == 4'h5 && cyc < 100) begin
         @(negedge clock);
         cyc++;
      end
      n_checks++;
      if (cyc !== 16 || db_a !== 4'hE || erro_a !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_erro: got %0d cycles state %h erro %b expected 16 E 1", cyc, db_a, erro_a);
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (db_a !== 4'hE || erro_a !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_hold: got %h erro %b expected E 1", db_a, erro_a);
      end
      ligar_a = 1'b0;
      @(negedge clock);
      n_checks++;
      if (db_a !== 4'h0 || erro_a !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_exit: got %h erro %b expected 0 0", db_a, erro_a);
      end
      auto_m_a = 1'b1;
      idle_a();
   endtask
`else
   task automatic test_no_timeout();
      bit ok;
      auto_m_a = 1'b0;
      ligar_a = 1'b1;
      wait_a(4'h5, -1, ok);
      repeat (40) @(negedge clock);
      n_checks++;
      if (ok !== 1'b1 || db_a !== 4'h5 || erro_a !== 1'b0) begin
         n_fail++;
         $display("FAIL no_tmo_wait: got %h erro %b expected 5 0", db_a, erro_a);
      end
      auto_m_a = 1'b1;
      idle_a();
   endtask
`endif

   task automatic test_done_on_timeout();
      bit ok;
      auto_m_a = 1'b0;
      ligar_a = 1'b1;
      wait_a(4'h5, -1, ok);
      repeat (15) @(negedge clock);
      n_checks++;
      if (ok !== 1'b1 || db_a !== 4'h5) begin
         n_fail++;
         $display("FAIL edge_wait: got %h expected 5", db_a);
      end
      med_man_a = 1'b1;
      @(negedge clock);
      med_man_a = 1'b0;
      n_checks++;
      if (db_a !== 4'h6 || erro_a !== 1'b0) begin
         n_fail++;
         $display("FAIL edge_done: got %h erro %b expected 6 0", db_a, erro_a);
      end
      auto_m_a = 1'b1;
      idle_a();
   endtask

   task automatic test_async_reset();
      bit ok;
      ligar_a = 1'b1;
      wait_a(4'h3, 1, ok);
      n_checks++;
      if (ok !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_reach: got %h pos %0d expected 3/1", db_a, pos_a);
      end
      auto_g_a = 1'b0;
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (db_a !== 4'h0 || pos_a !== 2'd0 || if_a.girar !== 1'b0 || erro_a !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_now: got %h pos %0d girar %b expected 0 0 0", db_a, pos_a, if_a.girar);
      end
      ligar_a = 1'b0;
      #1 reset = 1'b0;
      @(negedge clock);
      ligar_a = 1'b1;
      giro_man_a = 1'b1;
      @(negedge clock);
      giro_man_a = 1'b0;
      n_checks++;
      if (db_a !== 4'h1) begin
         n_fail++;
         $display("FAIL areset_prepara: got %h expected 1", db_a);
      end
      repeat (2) @(negedge clock);
      n_checks++;
      if (db_a !== 4'h3) begin
         n_fail++;
         $display("FAIL areset_wait: got %h expected 3", db_a);
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (db_a !== 4'h3) begin
         n_fail++;
         $display("FAIL areset_stale: got %h expected 3", db_a);
      end
      auto_g_a = 1'b1;
      idle_a();
   endtask

   initial begin
      reset = 1'b1;
      ligar_a = 1'b0; continuo_a = 1'b0; ligar_b = 1'b0; continuo_b = 1'b0;
      giro_man_a = 1'b0; med_man_a = 1'b0;
      auto_g_a = 1'b1; auto_m_a = 1'b1; auto_e_a = 1'b1;
      test_reset();
      test_single_sweep();
      test_continuous();
      test_abort();
`ifdef SONAR_UC_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      test_done_on_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
